// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the load/store port, one transaction outstanding.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed priority (data over inst).
module sram_bus_arbiter #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [1:0]  INST_SIZE = 2'b10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_inst_q, owner_inst_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                grant_inst, grant_data;
    logic                data_wins_tie;
    logic                resp;

`ifdef ARB_RR_EN
    logic last_inst_q, last_inst_d;
    assign data_wins_tie = last_inst_q;
`else
    assign data_wins_tie = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
`ifdef ARB_RR_EN
        last_inst_d  = last_inst_q;
`endif
        case (state_q)
            IDLE: begin
                // rst gating keeps addr_ok low while reset is held, since it is combinational on req
                if (!rst) begin
                    grant_data = data_req && (!inst_req || data_wins_tie);
                    grant_inst = inst_req && !grant_data;
                end
                if (grant_data) begin
                    state_d      = ADDR;
                    owner_inst_d = 1'b0;
                    wr_d         = data_wr;
                    size_d       = data_size;
                    wstrb_d      = data_wstrb;
                    addr_d       = data_addr;
                    wdata_d      = data_wdata;
                end else if (grant_inst) begin
                    state_d      = ADDR;
                    owner_inst_d = 1'b1;
                    wr_d         = 1'b0;
                    size_d       = INST_SIZE;
                    wstrb_d      = '0;
                    addr_d       = inst_addr;
                    wdata_d      = '0;
                end
`ifdef ARB_RR_EN
                if (grant_data || grant_inst) last_inst_d = grant_inst;
`endif
            end
            ADDR:    if (bus_addr_ok) state_d = WAIT;
            WAIT:    if (bus_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_inst_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef ARB_RR_EN
            last_inst_q  <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef ARB_RR_EN
            last_inst_q  <= last_inst_d;
`endif
        end
    end

    // Bus side is purely registered; response side is a same-cycle pass-through.
    assign resp         = (state_q == WAIT) && bus_data_ok;
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp && owner_inst_q;
    assign data_data_ok = resp && !owner_inst_q;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;
    assign bus_req      = (state_q == ADDR);
    assign bus_wr       = bus_req && wr_q;
    assign bus_size     = bus_req ? size_q  : 2'b00;
    assign bus_wstrb    = bus_req ? wstrb_q : '0;
    assign bus_addr     = bus_req ? addr_q  : '0;
    assign bus_wdata    = bus_req ? wdata_q : '0;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        bus_req, bus_wr, busy;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;

    sram_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        inst;
        bit        wr;
        bit [1:0]  size;
        bit [3:0]  wstrb;
        bit [31:0] addr;
        bit [31:0] wdata;
    } txn_t;

    int   vectors = 0;
    int   miscompares = 0;
    txn_t cur;
    bit   has_txn = 0, accepted = 0, last_inst = 1;
    bit   e_gi, e_gd, e_resp, e_breq;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Compare every output with what the transaction model says this cycle must show.
    task automatic eval();
        #1;
        e_gi = 0; e_gd = 0; e_resp = 0; e_breq = 0;
        if (rst) begin
            chk("rst_inst_addr_ok", inst_addr_ok, 0);
            chk("rst_data_addr_ok", data_addr_ok, 0);
            chk("rst_inst_data_ok", inst_data_ok, 0);
            chk("rst_data_data_ok", data_data_ok, 0);
            chk("rst_inst_rdata", inst_rdata, 0);
            chk("rst_data_rdata", data_rdata, 0);
            chk("rst_bus_req", bus_req, 0);
            chk("rst_bus_wr", bus_wr, 0);
            chk("rst_bus_size", bus_size, 0);
            chk("rst_bus_wstrb", bus_wstrb, 0);
            chk("rst_bus_addr", bus_addr, 0);
            chk("rst_bus_wdata", bus_wdata, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (!has_txn) begin
                if (data_req && inst_req) begin
`ifdef ARB_RR_EN
                    e_gd = last_inst;
`else
                    e_gd = 1;
`endif
                end else begin
                    e_gd = data_req;
                end
                e_gi = inst_req && !e_gd;
            end
            e_breq = has_txn && !accepted;
            e_resp = has_txn && accepted && bus_data_ok;
            chk("inst_addr_ok", inst_addr_ok, e_gi);
            chk("data_addr_ok", data_addr_ok, e_gd);
            chk("bus_req", bus_req, e_breq);
            chk("busy", busy, has_txn);
            chk("inst_data_ok", inst_data_ok, e_resp && cur.inst);
            chk("data_data_ok", data_data_ok, e_resp && !cur.inst);
            chk("inst_rdata", inst_rdata, (e_resp && cur.inst) ? bus_rdata : 32'h0);
            chk("data_rdata", data_rdata, (e_resp && !cur.inst) ? bus_rdata : 32'h0);
            if (e_breq) begin
                chk("bus_wr", bus_wr, cur.wr);
                chk("bus_size", bus_size, cur.size);
                chk("bus_wstrb", bus_wstrb, cur.wstrb);
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_wdata", bus_wdata, cur.wdata);
            end
        end
    endtask

    // Advance the model to what the coming clock edge does, then move to the next drive point.
    task automatic adv();
        if (rst) begin
            has_txn = 0; accepted = 0; last_inst = 1;
        end else if (!has_txn && (e_gi || e_gd)) begin
            cur.inst  = e_gi;
            cur.wr    = e_gi ? 1'b0 : data_wr;
            cur.size  = e_gi ? 2'b10 : data_size;
            cur.wstrb = e_gi ? 4'h0 : data_wstrb;
            cur.addr  = e_gi ? inst_addr : data_addr;
            cur.wdata = e_gi ? 32'h0 : data_wdata;
            has_txn = 1; accepted = 0; last_inst = e_gi;
        end else if (has_txn && !accepted && bus_addr_ok) begin
            accepted = 1;
        end else if (has_txn && accepted && bus_data_ok) begin
            has_txn = 0;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1; eval(); adv(); rst = 0;
    endtask

    int grants[$];
    int acc[$];
    int exp_order[4];
    int rem_d, rem_i;
    bit ih, dh;

    initial begin
        rst = 1; inst_req = 0; data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        @(negedge clk);
        eval(); chk("reset_busy", busy, 0); adv();
        rst = 0;

        // single fetch
        inst_req = 1; inst_addr = 32'hBFC00000;
        eval(); chk("t1_inst_addr_ok", inst_addr_ok, 1); adv();
        inst_req = 0; bus_addr_ok = 1;
        eval(); chk("t1_bus_req", bus_req, 1); chk("t1_bus_addr", bus_addr, 32'hBFC00000);
        chk("t1_bus_size", bus_size, 2); adv();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1A0001;
        eval(); chk("t1_inst_data_ok", inst_data_ok, 1); chk("t1_inst_rdata", inst_rdata, 32'h3C1A0001);
        chk("t1_data_data_ok", data_data_ok, 0); adv();
        bus_data_ok = 0; eval(); adv();

        // store byte with three address stalls
        data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b0100;
        data_addr = 32'h00000102; data_wdata = 32'h5A5A5A5A;
        eval(); chk("t2_data_addr_ok", data_addr_ok, 1); adv();
        data_req = 0; data_wr = 0; data_wstrb = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t2_bus_req", bus_req, 1); chk("t2_bus_wr", bus_wr, 1); chk("t2_bus_size", bus_size, 0);
            chk("t2_bus_wstrb", bus_wstrb, 4'b0100); chk("t2_bus_addr", bus_addr, 32'h00000102);
            chk("t2_bus_wdata", bus_wdata, 32'h5A5A5A5A);
            adv();
        end
        bus_addr_ok = 1; eval(); adv();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0;
        eval(); chk("t2_data_data_ok", data_data_ok, 1); chk("t2_inst_data_ok", inst_data_ok, 0); adv();
        bus_data_ok = 0; eval(); adv();

        // spurious bus_data_ok in IDLE and in ADDR
        bus_data_ok = 1; bus_rdata = 32'h12345678;
        eval(); chk("t5_idle_ddok", data_data_ok, 0); chk("t5_idle_idok", inst_data_ok, 0);
        chk("t5_idle_busy", busy, 0); adv();
        bus_data_ok = 0; data_req = 1; data_size = 2; data_addr = 32'h1000;
        eval(); adv();
        data_req = 0; bus_data_ok = 1;
        eval(); chk("t5_addr_ddok", data_data_ok, 0); chk("t5_addr_bus_req", bus_req, 1); adv();
        bus_data_ok = 0; bus_addr_ok = 1;
        eval(); chk("t5_addr_still", bus_req, 1); adv();
        bus_addr_ok = 0;

        // reset during WAIT drops the in-flight load
        rst = 1; inst_req = 1; data_req = 1;
        eval(); chk("t4_busy", busy, 0); chk("t4_data_addr_ok", data_addr_ok, 0); adv();
        rst = 0; inst_req = 0; data_req = 0; bus_data_ok = 1;
        eval(); chk("t4_stale_ddok", data_data_ok, 0); adv();
        bus_data_ok = 0; data_req = 1; data_addr = 32'h2000;
        eval(); chk("t4_new_addr_ok", data_addr_ok, 1); adv();
        data_req = 0; bus_addr_ok = 1; eval(); adv();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
        eval(); chk("t4_ddok", data_data_ok, 1); chk("t4_rdata", data_rdata, 32'hCAFEF00D); adv();
        bus_data_ok = 0; eval(); adv();

        // both ports requesting, one-cycle bus
        pulse_reset();
`ifdef ARB_RR_EN
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 1;
`endif
        rem_d = 2; rem_i = 2; bus_addr_ok = 1; bus_data_ok = 1;
        inst_addr = 32'h4000; data_addr = 32'h8000; data_wr = 0;
        for (int c = 0; c < 40 && (rem_d > 0 || rem_i > 0); c++) begin
            data_req = rem_d > 0; inst_req = rem_i > 0;
            eval();
            if (data_addr_ok) begin grants.push_back(0); rem_d--; end
            if (inst_addr_ok) begin grants.push_back(1); rem_i--; end
            adv();
        end
        data_req = 0; inst_req = 0;
        chk("t3_all_granted", rem_d + rem_i, 0);
        chk("t3_grant_count", grants.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("t3_order", (k < grants.size()) ? grants[k] : 9, exp_order[k]);
        for (int c = 0; c < 3; c++) begin eval(); adv(); end

        // back-to-back loads
        rem_d = 2;
        for (int c = 0; c < 20 && rem_d > 0; c++) begin
            data_req = 1;
            eval();
            if (data_addr_ok) begin acc.push_back(c); rem_d--; end
            adv();
        end
        data_req = 0;
        chk("t6_count", acc.size(), 2);
        chk("t6_spacing", (acc.size() == 2) ? acc[1] - acc[0] : 0, 3);
        bus_addr_ok = 0; bus_data_ok = 0;

        // randomized traffic
        ih = 0; dh = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!ih && $urandom_range(0, 3) == 0) begin
                ih = 1; inst_addr = $urandom;
            end
            if (!dh && $urandom_range(0, 3) == 0) begin
                dh = 1; data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom_range(0, 15)); data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = ih; data_req = dh;
            bus_addr_ok = ($urandom_range(0, 2) == 0);
            bus_data_ok = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            eval();
            if (e_gi) ih = 0;
            if (e_gd) dh = 0;
            adv();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
